// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux_scan_ctrl channel scanner.
// Holds the FSM state encoding, the channel count and the last channel index.
package mux_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int          NCH     = 4;
  localparam logic [1:0]  LAST_CH = 2'd3;

endpackage

// File: rtl/dwell_counter.sv
// Dwell counter for the channel scanner.
// Counts clock cycles while enabled and wraps to zero at DWELL-1.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   en       : count this cycle
//   clr      : force the count to zero (wins over en)
//   tc       : terminal count, high while the count equals DWELL-1
module dwell_counter #(
  parameter int DWELL = 2,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] count_r;

  assign tc = (count_r == TC_VAL);

  // Count register: cleared on reset/clear, wraps after the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en) begin
      if (tc) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + CNT_W'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/mux4x1.sv
// 4:1 bit multiplexer driven by the scanner.
// Ports:
//   din  : four data bits
//   sel  : channel select
//   dout : din[sel]
module mux4x1 (
  input  logic [3:0] din,
  input  logic [1:0] sel,
  output logic       dout
);

  assign dout = din[sel];

endmodule

// File: rtl/mux_scan_ctrl.sv
// Round-robin channel scanner for mux4x1.
// Steps sel through channels 0..3, holds each for DWELL cycles, samples dout
// at the end of each dwell and publishes the four samples as a snapshot over
// a valid/ready handshake.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   start    : begin a scan (honoured only when idle)
//   sel      : channel select to the mux
//   dout     : mux output, treated as combinational from sel
//   busy     : high while scanning or holding a snapshot
//   snap     : snapshot word, snap[i] sampled while sel == i
//   valid    : snap is complete and stable
//   ready    : consumer accepts snap when valid && ready
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int DWELL = 2,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [1:0] sel,
  input  logic       dout,
  output logic       busy,
  output logic [3:0] snap,
  output logic       valid,
  input  logic       ready
);

  state_t             state_r, state_nx;
  logic [1:0]         sel_r, sel_nx;
  logic               busy_r, busy_nx;
  logic               valid_r, valid_nx;
  logic [NCH-1:0]     shadow_r, shadow_nx;
  logic [NCH-1:0]     snap_r, snap_nx;
  logic               cnt_en_s, cnt_clr_s, cnt_tc_s;

  dwell_counter #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en_s),
    .clr (cnt_clr_s),
    .tc  (cnt_tc_s)
  );

  // Next-state and next-output logic for the scan FSM.
  always_comb begin
    state_nx  = state_r;
    sel_nx    = sel_r;
    busy_nx   = busy_r;
    valid_nx  = valid_r;
    shadow_nx = shadow_r;
    snap_nx   = snap_r;
    cnt_en_s  = 1'b0;
    cnt_clr_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_clr_s = 1'b1;
        if (start) begin
          state_nx = ST_SCAN;
          sel_nx   = 2'd0;
          busy_nx  = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_SCAN: begin
        cnt_en_s = 1'b1;
        if (cnt_tc_s) begin
          shadow_nx[sel_r] = dout;
          if (sel_r == LAST_CH) begin
            // Publish the whole word at once, including the bit taken now.
            state_nx = ST_HOLD;
            snap_nx  = shadow_nx;
            valid_nx = 1'b1;
          end else begin
            sel_nx = sel_r + 2'd1;
          end
        end else begin
          state_nx = ST_SCAN;
        end
      end
      ST_HOLD: begin
        // start is deliberately not looked at here, so it is never queued.
        if (ready) begin
          state_nx = ST_IDLE;
          valid_nx = 1'b0;
          busy_nx  = 1'b0;
          sel_nx   = 2'd0;
        end else begin
          state_nx = ST_HOLD;
        end
      end
      default: begin
        state_nx  = ST_IDLE;
        sel_nx    = 2'd0;
        busy_nx   = 1'b0;
        valid_nx  = 1'b0;
        cnt_clr_s = 1'b1;
      end
    endcase
  end

  // State and output registers; reset discards any partial shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      sel_r    <= 2'd0;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      shadow_r <= 4'b0000;
      snap_r   <= 4'b0000;
    end else begin
      state_r  <= state_nx;
      sel_r    <= sel_nx;
      busy_r   <= busy_nx;
      valid_r  <= valid_nx;
      shadow_r <= shadow_nx;
      snap_r   <= snap_nx;
    end
  end

  assign sel   = sel_r;
  assign busy  = busy_r;
  assign valid = valid_r;
  assign snap  = snap_r;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: three scanner+mux pairs (DWELL 2, 4, 1) on one
// clock. Directed stimulus pushes expected snapshots into a queue; a monitor
// pops and compares on every accepted handshake.
module tb_mux_scan_ctrl;

  typedef struct {
    int         ch;
    logic [3:0] snap;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start [3];
  logic       ready [3];
  logic [3:0] din   [3];
  logic [1:0] sel   [3];
  logic       dout  [3];
  logic       busy  [3];
  logic       valid [3];
  logic [3:0] snap  [3];

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   accepts = 0;
  int   cyc = 0;

  for (genvar g = 0; g < 3; g++) begin : g_ch
    mux_scan_ctrl #(
      .DWELL ((g == 0) ? 2 : ((g == 1) ? 4 : 1)),
      .CNT_W (4)
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start[g]),
      .sel   (sel[g]),
      .dout  (dout[g]),
      .busy  (busy[g]),
      .snap  (snap[g]),
      .valid (valid[g]),
      .ready (ready[g])
    );
    mux4x1 u_mux (
      .din  (din[g]),
      .sel  (sel[g]),
      .dout (dout[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted handshake must match the head of the queue.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (!rst && valid[g] && ready[g]) begin
        accepts++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_snap: ch%0d snap %b with nothing expected", g, snap[g]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.ch != g || snap[g] !== e.snap) begin
            fails++;
            $display("FAIL snap_ch%0d: got ch%0d snap %b expected ch%0d snap %b",
                     g, g, snap[g], e.ch, e.snap);
          end
        end
      end
    end
  end

  // Assumes caller sits #1 after an edge; returns #1 after the start edge.
  task automatic pulse_start(input int ch);
    start[ch] = 1'b1;
    @(posedge clk); #1;
    start[ch] = 1'b0;
  endtask

  task automatic wait_valid(input int ch);
    int n = 0;
    while (!valid[ch] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("valid_timeout", {31'd0, valid[ch]}, 32'd1);
  endtask

  task automatic wait_idle(input int ch);
    int n = 0;
    while (busy[ch] && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", {31'd0, busy[ch]}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int e0_prev;
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      start[g] = 1'b0;
      ready[g] = 1'b0;
      din[g]   = 4'b0000;
    end
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    for (int g = 0; g < 3; g++) begin
      check("rst_sel",   {30'd0, sel[g]},   32'd0);
      check("rst_busy",  {31'd0, busy[g]},  32'd0);
      check("rst_valid", {31'd0, valid[g]}, 32'd0);
      check("rst_snap",  {28'd0, snap[g]},  32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic scan, DWELL=2
    din[0] = 4'b1010;
    ready[0] = 1'b1;
    exp_q.push_back('{ch: 0, snap: 4'b1010});
    pulse_start(0);
    check("basic_busy", {31'd0, busy[0]}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("basic_sel",   {30'd0, sel[0]},   32'(i / 2));
      check("basic_valid", {31'd0, valid[0]}, 32'd0);
      @(posedge clk); #1;
    end
    check("basic_valid_rise", {31'd0, valid[0]}, 32'd1);
    check("basic_snap", {28'd0, snap[0]}, 32'b1010);
    check("basic_sel3", {30'd0, sel[0]}, 32'd3);
    @(posedge clk); #1;
    check("basic_valid_fall", {31'd0, valid[0]}, 32'd0);
    check("basic_busy_fall",  {31'd0, busy[0]},  32'd0);
    check("basic_sel0",       {30'd0, sel[0]},   32'd0);
    check("basic_snap_keep",  {28'd0, snap[0]},  32'b1010);

    // Back-pressure
    din[0] = 4'b0110;
    ready[0] = 1'b0;
    exp_q.push_back('{ch: 0, snap: 4'b0110});
    pulse_start(0);
    wait_valid(0);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", {31'd0, valid[0]}, 32'd1);
      check("bp_snap",  {28'd0, snap[0]},  32'b0110);
      check("bp_sel",   {30'd0, sel[0]},   32'd3);
      check("bp_busy",  {31'd0, busy[0]},  32'd1);
      @(posedge clk); #1;
    end
    ready[0] = 1'b1;
    din[0] = 4'b1111;
    @(posedge clk); #1;
    check("bp_valid_fall", {31'd0, valid[0]}, 32'd0);
    check("bp_busy_fall",  {31'd0, busy[0]},  32'd0);
    check("bp_snap_keep",  {28'd0, snap[0]},  32'b0110);

    // Ignored start in SCAN and on the handshake edge
    din[0] = 4'b0011;
    exp_q.push_back('{ch: 0, snap: 4'b0011});
    pulse_start(0);
    repeat (2) @(posedge clk);
    #1;
    pulse_start(0);
    wait_valid(0);
    pulse_start(0);
    check("ign_busy",  {31'd0, busy[0]},  32'd0);
    check("ign_valid", {31'd0, valid[0]}, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check("ign_stay_idle", {31'd0, busy[0]}, 32'd0);
    check("ign_snap", {28'd0, snap[0]}, 32'b0011);

    // Data change mid-scan, DWELL=4
    din[1] = 4'b0000;
    ready[1] = 1'b1;
    exp_q.push_back('{ch: 1, snap: 4'b1100});
    pulse_start(1);
    repeat (8) @(posedge clk);
    #1;
    din[1] = 4'b1111;
    wait_valid(1);
    check("chg_latency_sel", {30'd0, sel[1]}, 32'd3);
    wait_idle(1);
    check("chg_snap", {28'd0, snap[1]}, 32'b1100);

    // Asynchronous reset during channel 2
    din[0] = 4'b1111;
    pulse_start(0);
    repeat (4) @(posedge clk);
    #1;
    check("ar_pre_sel", {30'd0, sel[0]}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("ar_sel",    {30'd0, sel[0]},   32'd0);
    check("ar_busy",   {31'd0, busy[0]},  32'd0);
    check("ar_valid",  {31'd0, valid[0]}, 32'd0);
    check("ar_snap",   {28'd0, snap[0]},  32'd0);
    check("ar_snap1",  {28'd0, snap[1]},  32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    din[0] = 4'b0001;
    exp_q.push_back('{ch: 0, snap: 4'b0001});
    pulse_start(0);
    wait_idle(0);
    check("ar_rescan_snap", {28'd0, snap[0]}, 32'b0001);

    // DWELL=1 back-to-back throughput
    din[2] = 4'b1001;
    ready[2] = 1'b1;
    e0_prev = 0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('{ch: 2, snap: 4'b1001});
      pulse_start(2);
      e0 = cyc;
      if (k > 0) check("thr_period", 32'(e0 - e0_prev), 32'd6);
      e0_prev = e0;
      wait_valid(2);
      check("thr_latency", 32'(cyc - e0), 32'd4);
      check("thr_snap", {28'd0, snap[2]}, 32'b1001);
      @(posedge clk); #1;
      check("thr_handshake", {31'd0, valid[2]}, 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;

    check("accept_count", 32'(accepts), 32'd8);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
